phys_reg_freelist: RTL and testbench
====================================

Name: phys_reg_freelist

Overview:
Allocator for the 64-entry physical register file. Circular free list of physical register tags.
- Rename stage pulls up to two free tags per cycle.
- Commit returns up to two retired tags per cycle.
- P0 is hard-wired zero: never handed out, never accepted back.

Parameters:
REG_SIZE, 64, number of physical registers; also the free-list depth (power of two)
REG_SIZE_WIDTH, 6, log2(REG_SIZE); tag and pointer width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
alloc_req_first_i  input  1  rename slot 0 needs a tag
alloc_req_second_i  input  1  rename slot 1 needs a tag
alloc_grant_o  output  1  all requested tags available this cycle
alloc_prd_first_o  output  REG_SIZE_WIDTH  tag for slot 0
alloc_prd_second_o  output  REG_SIZE_WIDTH  tag for slot 1
free_valid_first_i  input  1  commit slot 0 returns a tag
free_prd_first_i  input  REG_SIZE_WIDTH  returned tag, slot 0
free_valid_second_i  input  1  commit slot 1 returns a tag
free_prd_second_i  input  REG_SIZE_WIDTH  returned tag, slot 1
free_count_o  output  REG_SIZE_WIDTH+1  tags currently held
empty_o  output  1  free_count_o == 0
overflow_err_o  output  1  sticky: a return was dropped

Behaviour:
- Storage: entry array[REG_SIZE] of tags; head, tail pointers (REG_SIZE_WIDTH bits, natural wrap); count (REG_SIZE_WIDTH+1 bits).
- Reset (async, any time including mid-operation):
  - entry[i] = i+1 for i in 0..REG_SIZE-2; entry[REG_SIZE-1] = 0.
  - head = 0, tail = REG_SIZE-1, count = REG_SIZE-1, overflow_err_o = 0.
  - In-flight requests and returns are discarded.
- Reset output values: free_count_o = 63, empty_o = 0, alloc_prd_first_o = 1, alloc_prd_second_o = 2. alloc_grant_o = 1 whenever at most one request is raised, or both are raised (count 63 covers two).
- Allocation (combinational outputs, pointer update on clk):
  - n_req = alloc_req_first_i + alloc_req_second_i.
  - alloc_grant_o = (count >= n_req). With n_req = 0 it is 1.
  - Both requested: first = entry[head], second = entry[head+1].
  - Only second requested: second = entry[head].
  - Only first requested: first = entry[head].
  - Unrequested outputs show entry[head] / entry[head+1] and are don't-care.
  - All-or-nothing: if the grant is low, no tag is consumed and head and count are unchanged.
  - On grant: head += n_req (mod REG_SIZE).
- Release (registered; a freed tag is allocatable from the next cycle, never the same cycle):
  - Returns with tag 0 are silently ignored.
  - Accepted returns are written at tail, then tail+1, in slot order (first before second); tail += n_free.
  - Capacity check uses count_after_alloc = count - granted n_req.
  - A return that would push count above REG_SIZE is dropped (second slot dropped first) and overflow_err_o is set. The error clears only on rst.
- Count update: count_next = count - granted n_req + accepted n_free. Simultaneous alloc and free in one cycle is legal.
- No duplicate-tag checking; double-free protection belongs to commit logic.
- Pointer wrap is implicit in the REG_SIZE_WIDTH-bit arithmetic. Head may equal tail only when count is 0 or REG_SIZE.

Test Plan:
1. Reset check: assert rst for 2 cycles, release, no requests -> free_count_o = 63, alloc_prd_first_o = 1, alloc_prd_second_o = 2, empty_o = 0, overflow_err_o = 0.
2. Drain: double request for 31 cycles -> grants yield P1..P62 in order, free_count_o = 1. Next cycle double request -> alloc_grant_o = 0, count stays 1. Then single request -> P63, empty_o = 1.
3. Refill and wrap: from empty, free P5 (first) and P9 (second) in one cycle; same cycle double request -> grant 0. Next cycle double request -> grant 1, tags P5, P9 (entry[63] then wrapped entry[0]), count 0.
4. Simultaneous: at count 10, double alloc plus double free of P20, P21 in one cycle -> count stays 10. The granted tags are the pre-existing head entries, not P20/P21.
5. P0 and second-only: free_valid_first_i with tag 0 -> count unchanged. Only alloc_req_second_i after reset -> alloc_prd_second_o = 1, count 62.
6. Overflow and async reset: after reset, free P7 -> count 64. Next cycle free P8 -> dropped, overflow_err_o = 1, count 64. Assert rst mid-cycle -> all state returns to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/phys_reg_freelist.sv
// Circular free list of physical register tags.
// Two allocations and two returns per cycle; tag 0 never circulates.
module phys_reg_freelist #(
   parameter int REG_SIZE       = 64,
   parameter int REG_SIZE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alloc_req_first_i,
   input  logic                      alloc_req_second_i,
   output logic                      alloc_grant_o,
   output logic [REG_SIZE_WIDTH-1:0] alloc_prd_first_o,
   output logic [REG_SIZE_WIDTH-1:0] alloc_prd_second_o,
   input  logic                      free_valid_first_i,
   input  logic [REG_SIZE_WIDTH-1:0] free_prd_first_i,
   input  logic                      free_valid_second_i,
   input  logic [REG_SIZE_WIDTH-1:0] free_prd_second_i,
   output logic [REG_SIZE_WIDTH:0]   free_count_o,
   output logic                      empty_o,
   output logic                      overflow_err_o
);

   localparam int PW = REG_SIZE_WIDTH;
   localparam int CW = REG_SIZE_WIDTH + 1;

   logic [PW-1:0] entry [REG_SIZE];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic          overflow_err;

   logic [1:0]    n_req;
   logic [1:0]    n_alloc;
   logic [1:0]    n_free;
   logic          grant;
   logic [CW-1:0] count_after;
   logic [CW-1:0] count_mid;
   logic          want_first;
   logic          want_second;
   logic          acc_first;
   logic          acc_second;
   logic          drop;
   logic [PW-1:0] tail_second;

   always_comb begin
      n_req   = {1'b0, alloc_req_first_i} + {1'b0, alloc_req_second_i};
      grant   = (count >= CW'(n_req));
      n_alloc = grant ? n_req : 2'd0;
      count_after = count - CW'(n_alloc);

      // Capacity is judged after this cycle's allocation; slot 1 loses first.
      want_first  = free_valid_first_i  && (free_prd_first_i  != '0);
      want_second = free_valid_second_i && (free_prd_second_i != '0);
      acc_first   = want_first && (count_after < CW'(REG_SIZE));
      count_mid   = count_after + CW'(acc_first);
      acc_second  = want_second && (count_mid < CW'(REG_SIZE));
      drop        = (want_first & ~acc_first) | (want_second & ~acc_second);
      n_free      = {1'b0, acc_first} + {1'b0, acc_second};
      tail_second = tail + PW'(acc_first);
   end

   assign alloc_grant_o     = grant;
   assign alloc_prd_first_o = entry[head];
   assign alloc_prd_second_o =
      (alloc_req_second_i & ~alloc_req_first_i) ? entry[head]
                                                : entry[head + PW'(1)];
   assign free_count_o   = count;
   assign empty_o        = (count == '0);
   assign overflow_err_o = overflow_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_SIZE; i++)
            entry[i] <= (i == REG_SIZE - 1) ? '0 : PW'(i + 1);
      end else begin
         if (acc_first)
            entry[tail] <= free_prd_first_i;
         if (acc_second)
            entry[tail_second] <= free_prd_second_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head         <= '0;
         tail         <= PW'(REG_SIZE - 1);
         count        <= CW'(REG_SIZE - 1);
         overflow_err <= 1'b0;
      end else begin
         head  <= head + PW'(n_alloc);
         tail  <= tail + PW'(n_free);
         count <= count_after + CW'(n_free);
         if (drop)
            overflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Bench for phys_reg_freelist: vector table plus drain and async-reset
// sequences, with post-edge state checked through a scoreboard queue.
module tb_phys_reg_freelist;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic       grant;
   logic [5:0] prd0, prd1;
   logic       fv0, fv1;
   logic [5:0] fp0, fp1;
   logic [6:0] cnt;
   logic       empty;
   logic       ovf;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit         pre_rst;
      bit         r0, r1;
      bit         f0v;
      logic [5:0] f0;
      bit         f1v;
      logic [5:0] f1;
      bit         g;
      bit         c0;
      logic [5:0] t0;
      bit         c1;
      logic [5:0] t1;
      logic [6:0] cnt;
      bit         ovf;
   } vec_t;

   typedef struct {
      string      name;
      logic [6:0] cnt;
      bit         ovf;
   } exp_t;

   exp_t sb[$];
   vec_t vt[15];

   phys_reg_freelist #(.REG_SIZE(64), .REG_SIZE_WIDTH(6)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .alloc_req_first_i   (req0),
      .alloc_req_second_i  (req1),
      .alloc_grant_o       (grant),
      .alloc_prd_first_o   (prd0),
      .alloc_prd_second_o  (prd1),
      .free_valid_first_i  (fv0),
      .free_prd_first_i    (fp0),
      .free_valid_second_i (fv1),
      .free_prd_second_i   (fp1),
      .free_count_o        (cnt),
      .empty_o             (empty),
      .overflow_err_o      (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req0 = 0; req1 = 0; fv0 = 0; fv1 = 0; fp0 = '0; fp1 = '0;
   endtask

   // Called at a negedge; leaves the bench at a negedge with rst low.
   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Drive at negedge, check combinational outputs, queue post-edge state.
   task automatic apply(input string name, input vec_t v);
      exp_t e, got;
      if (v.pre_rst) do_reset();
      req0 = v.r0; req1 = v.r1;
      fv0 = v.f0v; fp0 = v.f0; fv1 = v.f1v; fp1 = v.f1;
      #1;
      check({name, " grant"}, grant, v.g);
      if (v.c0) check({name, " prd_first"}, prd0, v.t0);
      if (v.c1) check({name, " prd_second"}, prd1, v.t1);
      e.name = name; e.cnt = v.cnt; e.ovf = v.ovf;
      sb.push_back(e);
      @(posedge clk);
      #1;
      idle_inputs();
      if (sb.size() == 0) begin
         check({name, " scoreboard"}, 0, 1);
      end else begin
         got = sb.pop_front();
         check({got.name, " count"}, cnt, got.cnt);
         check({got.name, " empty"}, empty, got.cnt == 0);
         check({got.name, " overflow"}, ovf, got.ovf);
      end
      @(negedge clk);
   endtask

   function automatic vec_t mk(bit pr, bit r0, bit r1,
                               bit f0v, int f0, bit f1v, int f1,
                               bit g, bit c0, int t0, bit c1, int t1,
                               int c, bit o);
      vec_t v;
      v.pre_rst = pr; v.r0 = r0; v.r1 = r1;
      v.f0v = f0v; v.f0 = 6'(f0); v.f1v = f1v; v.f1 = 6'(f1);
      v.g = g; v.c0 = c0; v.t0 = 6'(t0); v.c1 = c1; v.t1 = 6'(t1);
      v.cnt = 7'(c); v.ovf = o;
      return v;
   endfunction

   initial begin
      // Starts after the drain: count 0, head 63, tail 63.
      vt[0]  = mk(0,1,1, 1,5, 1,9,   0, 0,0, 0,0,  2, 0);
      vt[1]  = mk(0,1,1, 0,0, 0,0,   1, 1,5, 1,9,  0, 0);
      vt[2]  = mk(0,0,0, 1,30,1,31,  1, 0,0, 0,0,  2, 0);
      vt[3]  = mk(0,0,0, 1,32,1,33,  1, 0,0, 0,0,  4, 0);
      vt[4]  = mk(0,0,0, 1,34,1,35,  1, 0,0, 0,0,  6, 0);
      vt[5]  = mk(0,0,0, 1,36,1,37,  1, 0,0, 0,0,  8, 0);
      vt[6]  = mk(0,0,0, 1,38,1,39,  1, 0,0, 0,0, 10, 0);
      vt[7]  = mk(0,1,1, 1,20,1,21,  1, 1,30,1,31, 10, 0);
      vt[8]  = mk(0,0,0, 1,0, 1,0,   1, 0,0, 0,0, 10, 0);
      vt[9]  = mk(1,0,1, 0,0, 0,0,   1, 0,0, 1,1, 62, 0);
      vt[10] = mk(1,0,0, 1,7, 0,0,   1, 0,0, 0,0, 64, 0);
      vt[11] = mk(0,0,0, 1,8, 0,0,   1, 0,0, 0,0, 64, 1);
      vt[12] = mk(0,1,1, 0,0, 0,0,   1, 1,1, 1,2, 62, 1);
      vt[13] = mk(1,1,0, 1,7, 1,8,   1, 1,1, 0,0, 64, 0);
      vt[14] = mk(1,0,0, 1,7, 1,8,   1, 0,0, 0,0, 64, 1);

      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      do_reset();
      #1;
      check("reset count", cnt, 63);
      check("reset prd_first", prd0, 1);
      check("reset prd_second", prd1, 2);
      check("reset empty", empty, 0);
      check("reset overflow", ovf, 0);
      check("reset grant", grant, 1);
      @(negedge clk);

      for (int k = 0; k < 31; k++)
         apply($sformatf("drain%0d", k),
               mk(0,1,1, 0,0, 0,0, 1, 1,2*k+1, 1,2*k+2, 61-2*k, 0));
      apply("drain_deny", mk(0,1,1, 0,0, 0,0, 0, 0,0, 0,0, 1, 0));
      apply("drain_last", mk(0,1,0, 0,0, 0,0, 1, 1,63, 0,0, 0, 0));

      for (int i = 0; i < 15; i++)
         apply($sformatf("vec%0d", i), vt[i]);

      // Asynchronous reset landing between clock edges.
      #2;
      req0 = 1; req1 = 1;
      rst = 1'b1;
      #1;
      check("async count", cnt, 63);
      check("async overflow", ovf, 0);
      check("async prd_first", prd0, 1);
      check("async prd_second", prd1, 2);
      check("async empty", empty, 0);
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      #1;
      check("post_async count", cnt, 63);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
